// File: rtl/hamming74_pkg.sv
// Shared definitions for the streaming Hamming(7,4) encoder.
// Holds code word bit positions, FSM states and the nibble encoding function.
package hamming74_pkg;

  localparam int P1_POS  = 0;
  localparam int P2_POS  = 1;
  localparam int D0_POS  = 2;
  localparam int P4_POS  = 3;
  localparam int D1_POS  = 4;
  localparam int D2_POS  = 5;
  localparam int D3_POS  = 6;
  localparam int EXT_POS = 7;
  localparam int SEL_POS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_e;

  function automatic logic [6:0] hamming74_encode(input logic [3:0] nibble);
    logic [6:0] cw;
    cw         = '0;
    cw[D0_POS] = nibble[0];
    cw[D1_POS] = nibble[1];
    cw[D2_POS] = nibble[2];
    cw[D3_POS] = nibble[3];
    cw[P1_POS] = nibble[0] ^ nibble[1] ^ nibble[3];
    cw[P2_POS] = nibble[0] ^ nibble[2] ^ nibble[3];
    cw[P4_POS] = nibble[1] ^ nibble[2] ^ nibble[3];
    return cw;
  endfunction

endpackage

// File: rtl/hamming74_enc_stream_if.sv
// Byte-in / code-word-out valid/ready bundle of the Hamming(7,4) stream encoder.
// slave is the encoder side, master is the surrounding producer/consumer.
interface hamming74_enc_stream_if;

  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [8:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid
  );

endinterface

// File: rtl/hamming74_enc_core.sv
// Combinational nibble to 8-bit code word encoder (7 Hamming bits + ext parity).
// HAMMING74_EXT_PARITY_EN adds even overall parity in bit 7; otherwise bit 7 is 0.
module hamming74_enc_core
  import hamming74_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] code
);

  logic [6:0] cw;

  assign cw = hamming74_encode(nibble);

`ifdef HAMMING74_EXT_PARITY_EN
  assign code = {^cw, cw};
`else
  assign code = {1'b0, cw};
`endif

endmodule

// File: rtl/hamming74_enc_stream.sv
// Streaming Hamming(7,4) encoder: one byte in, two 9-bit code words out (low nibble first).
// Optional SECDED bit 7 via HAMMING74_EXT_PARITY_EN (see hamming74_enc_core).
module hamming74_enc_stream
  import hamming74_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  hamming74_enc_stream_if.slave bus,
  output logic [CNT_W-1:0]     o_cw_count
);

  state_e     state;
  logic [3:0] hi_nib_q;
  logic [8:0] data_q;
  logic       valid_q;
  logic [3:0] core_nib;
  logic [7:0] core_code;
  logic       byte_hs;
  logic       word_hs;

  // While the low word is outstanding the core encodes the held high nibble;
  // in every other state it encodes the low nibble of the byte being offered.
  assign core_nib = (state == S_LO) ? hi_nib_q : bus.i_data[3:0];

  hamming74_enc_core u_core (
    .nibble (core_nib),
    .code   (core_code)
  );

  assign bus.o_ready = !i_rst && ((state == S_IDLE) || ((state == S_HI) && bus.i_ready));
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;

  assign byte_hs = bus.i_valid & bus.o_ready;
  assign word_hs = valid_q & bus.i_ready;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      hi_nib_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (byte_hs) begin
            hi_nib_q <= bus.i_data[7:4];
            data_q   <= {1'b0, core_code};
            valid_q  <= 1'b1;
            state    <= S_LO;
          end
        end
        S_LO: begin
          if (word_hs) begin
            data_q <= {1'b1, core_code};
            state  <= S_HI;
          end
        end
        S_HI: begin
          if (word_hs) begin
            if (byte_hs) begin
              hi_nib_q <= bus.i_data[7:4];
              data_q   <= {1'b0, core_code};
              state    <= S_LO;
            end else begin
              valid_q <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cw_count <= '0;
    end else if (word_hs) begin
      o_cw_count <= o_cw_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming74_enc_stream.sv
// Self-checking bench for hamming74_enc_stream: table vectors, corner sequences,
// and random traffic scored against a position-based Hamming model and word queue.
module tb_hamming74_enc_stream;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] cw_count;
  logic [3:0]  cw_count4;

  always #5 i_clk = ~i_clk;

  hamming74_enc_stream_if ifc ();
  hamming74_enc_stream_if ifc4 ();

  assign ifc4.i_data  = ifc.i_data;
  assign ifc4.i_valid = ifc.i_valid;
  assign ifc4.i_ready = ifc.i_ready;

  hamming74_enc_stream #(.CNT_W(16)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (ifc),
    .o_cw_count (cw_count)
  );

  hamming74_enc_stream #(.CNT_W(4)) dut4 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (ifc4),
    .o_cw_count (cw_count4)
  );

  typedef struct {
    logic [7:0] byte_in;
    logic [8:0] lo_word;
    logic [8:0] hi_word;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  int         exp_cnt  = 0;
  int         n_bytes  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: place data at non-power-of-two positions 1..7, then each parity at
  // position 2^k covers every position whose index has bit k set.
  function automatic logic [8:0] model_word(input logic [3:0] nib, input bit hi);
    logic [7:1] pos;
    logic [8:0] w;
    int         di;
    pos = '0;
    di  = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = nib[di];
        di++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (((p >> k) & 1) == 1 && p != (1 << k)) par = par ^ pos[p];
      pos[1 << k] = par;
    end
    w = {hi, 1'b0, pos[7:1]};
`ifdef HAMMING74_EXT_PARITY_EN
    w[7] = ^pos[7:1];
`endif
    return w;
  endfunction

  // Called at a negedge with inputs already set; checks outputs against the model,
  // advances the model by the handshakes of the coming edge, ends at next negedge.
  task automatic step(output bit got, output logic [8:0] word);
    bit byte_hs, word_hs;
    #1;
    check("o_valid", 32'(ifc.o_valid), 32'(exp_q.size() != 0));
    check("o_ready", 32'(ifc.o_ready),
          32'(exp_q.size() == 0 || (exp_q.size() == 1 && ifc.i_ready)));
    if (exp_q.size() != 0) check("o_data", 32'(ifc.o_data), 32'(exp_q[0]));
    check("o_cw_count", 32'(cw_count), 32'(exp_cnt & 16'hFFFF));
    check("o_cw_count_w4", 32'(cw_count4), 32'(exp_cnt & 15));
    word_hs = ifc.o_valid && ifc.i_ready;
    byte_hs = ifc.i_valid && ifc.o_ready;
    got     = word_hs;
    word    = ifc.o_data;
    if (word_hs && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (byte_hs) begin
      exp_q.push_back(model_word(ifc.i_data[3:0], 1'b0));
      exp_q.push_back(model_word(ifc.i_data[7:4], 1'b1));
      n_bytes++;
    end
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst       = 1'b1;
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b0;
    ifc.i_data  = 8'h00;
    #1;
    check("rst_o_valid", 32'(ifc.o_valid), 32'd0);
    check("rst_o_data", 32'(ifc.o_data), 32'd0);
    check("rst_count", 32'(cw_count), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
  endtask

  bit         got;
  logic [8:0] word;
  logic [8:0] seq[4];
  vec_t       vecs[4];
  int         guard;

  initial begin
    vecs[0] = '{8'h5B, 9'h055, 9'h12D};
`ifdef HAMMING74_EXT_PARITY_EN
    vecs[1] = '{8'h1F, 9'h0FF, 9'h187};
    vecs[3] = '{8'hFF, 9'h0FF, 9'h1FF};
`else
    vecs[1] = '{8'h1F, 9'h07F, 9'h107};
    vecs[3] = '{8'hFF, 9'h07F, 9'h17F};
`endif
    vecs[2] = '{8'h00, 9'h000, 9'h100};

    i_rst       = 1'b1;
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b0;
    ifc.i_data  = 8'h00;
    #1;
    check("async_rst_valid", 32'(ifc.o_valid), 32'd0);
    do_reset();
    step(got, word);

    // Table vectors, i_ready held high
    for (int i = 0; i < 4; i++) begin
      ifc.i_ready = 1'b1;
      ifc.i_valid = 1'b1;
      ifc.i_data  = vecs[i].byte_in;
      step(got, word);
      ifc.i_valid = 1'b0;
      ifc.i_data  = 8'($urandom);
      step(got, word);
      check($sformatf("vec%0d_lo_hs", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_lo", i), 32'(word), 32'(vecs[i].lo_word));
      step(got, word);
      check($sformatf("vec%0d_hi_hs", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_hi", i), 32'(word), 32'(vecs[i].hi_word));
      step(got, word);
    end
    check("count_after_table", 32'(cw_count), 32'd8);

    // Back-to-back 0x00, 0xFF with i_valid held high
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'h00;
    step(got, word);
    ifc.i_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step(got, word);
      check($sformatf("b2b_hs%0d", i), 32'(got), 32'd1);
      seq[i] = word;
      if (i == 1) ifc.i_valid = 1'b0;
    end
    check("b2b_w0", 32'(seq[0]), 32'(vecs[2].lo_word));
    check("b2b_w1", 32'(seq[1]), 32'(vecs[2].hi_word));
    check("b2b_w2", 32'(seq[2]), 32'(vecs[3].lo_word));
    check("b2b_w3", 32'(seq[3]), 32'(vecs[3].hi_word));
    step(got, word);

    // Downstream stall while the low word of 0x5B is presented
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'h5B;
    step(got, word);
    ifc.i_ready = 1'b0;
    ifc.i_data  = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      step(got, word);
      check("stall_no_hs", 32'(got), 32'd0);
      check("stall_data", 32'(ifc.o_data), 32'h055);
    end
    check("stall_count", 32'(cw_count), 32'd12);
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    step(got, word);
    check("stall_release_lo", 32'(word), 32'h055);
    step(got, word);
    check("stall_release_hi", 32'(word), 32'h12D);
    step(got, word);

    // Reset while in S_LO
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'hA3;
    ifc.i_ready = 1'b0;
    step(got, word);
    i_rst = 1'b1;
    #1;
    check("midrst_valid", 32'(ifc.o_valid), 32'd0);
    check("midrst_count", 32'(cw_count), 32'd0);
    check("midrst_count4", 32'(cw_count4), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    exp_cnt     = 0;
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    step(got, word);
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'h5B;
    step(got, word);
    ifc.i_valid = 1'b0;
    step(got, word);
    check("post_rst_lo", 32'(word), 32'h055);
    step(got, word);
    check("post_rst_hi", 32'(word), 32'h12D);

    // Counter wrap on the 4-bit instance: 9 bytes = 18 words
    do_reset();
    ifc.i_ready = 1'b1;
    ifc.i_valid = 1'b1;
    n_bytes     = 0;
    guard       = 0;
    while (n_bytes < 9 && guard < 100) begin
      ifc.i_data = 8'($urandom);
      step(got, word);
      guard++;
    end
    ifc.i_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 200) begin
      step(got, word);
      guard++;
    end
    check("wrap_bytes", 32'(n_bytes), 32'd9);
    check("wrap_count4", 32'(cw_count4), 32'd2);
    check("wrap_count16", 32'(cw_count), 32'd18);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      ifc.i_valid = 1'($urandom_range(0, 2) != 0);
      ifc.i_ready = 1'($urandom_range(0, 3) != 0);
      ifc.i_data  = 8'($urandom);
      step(got, word);
    end
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(got, word);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
